split16_arbiter: RTL and testbench
==================================

# split16_arbiter

Shares the CPU's single 16→8 word splitter between two 16-bit requesters (requester 0: PC/address push; requester 1: ALU/register-pair writeback) and sequences each accepted word onto the 8-bit internal data bus as two bytes. The block arbitrates round-robin, latches the winning word, and emits it as low byte then high byte by default, with a valid/ready handshake on both sides. It sits between the 16-bit producers and the 8-bit bus driver.

## Interface
Parameters:
- LOW_FIRST, 1, 1 = emit bits [7:0] first and [15:8] second; 0 = emit high byte first.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  16  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle when high together with req0_valid.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  16  requester 1 word.
- req1_ready  out  1  requester 1 accept, same rule as req0_ready.
- out_valid  out  1  byte on out_data is valid.
- out_data  out  8  current byte.
- out_last  out  1  high on the second byte of a word.
- out_src  out  1  requester index owning the current word.
- out_ready  in  1  bus consumer takes the byte when high together with out_valid.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, BYTE0, BYTE1.
- IDLE: grant computed combinationally from valids and the round-robin pointer last_grant.
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = (state == IDLE) && grant == N. Neither ready is high outside IDLE. Neither ready is high when that requester is not granted.
  - On accept: latch the 16-bit word into word_reg and the index into src_reg, set last_grant = granted index, go to BYTE0.
- BYTE0:
  - out_valid = 1, out_last = 0.
  - out_data = word_reg[7:0] if LOW_FIRST, else word_reg[15:8].
  - When out_ready is high: go to BYTE1. Otherwise hold.
- BYTE1:
  - out_valid = 1, out_last = 1, out_data = the other byte.
  - When out_ready is high: go to IDLE. Otherwise hold.
- out_src = src_reg in BYTE0/BYTE1; 0 in IDLE.
- out_data, out_last, out_src remain stable while out_valid && !out_ready.
- Requester data is sampled only at the accept edge. Later changes to reqN_data have no effect on the word in flight.
- last_grant changes only on accept. It does not change when valids are dropped in IDLE.
- A requester deasserting valid before it is granted is legal; no state change results.
- No new word is accepted during BYTE0/BYTE1, even if out_ready is high in BYTE1.

## Timing
- Reset (rst high at a clock edge), effective the following cycle:
  - state = IDLE, out_valid = 0, out_data = 8'h00, out_last = 0, out_src = 0, busy = 0, word_reg = 0, src_reg = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- Reset mid-word (BYTE0 or BYTE1): the in-flight word is discarded, no further bytes are emitted, and state is IDLE on the next cycle.
- Latency: accept at edge N → out_valid high in cycle N+1 with byte 0.
- With out_ready held high: byte 1 in cycle N+2, IDLE in cycle N+3, next accept possible at edge N+3. Throughput is one word per 3 cycles.
- Backpressure stretches BYTE0/BYTE1 indefinitely. Outputs are frozen and both readies stay 0.
- Ready is combinational from state, valids and last_grant. There is no combinational path from out_ready to reqN_ready.

## Test plan
- Single word, LOW_FIRST=1: req0 sends 16'hA55A, out_ready=1.
  - Required: req0_ready high in IDLE.
  - Next cycle: out_data=8'h5A, out_last=0, out_src=0.
  - Then: 8'hA5, out_last=1.
  - Then: busy=0.
- Contention and fairness: req0=16'h1234 and req1=16'hBEEF, both valid continuously after reset.
  - Required grant order: req0, req1, req0, req1.
  - Byte stream: 34, 12, EF, BE, 34, 12, ….
  - out_src alternates 0, 1.
- Backpressure: req1 sends 16'h00FF; out_ready low for 4 cycles in BYTE0, then high; later low 2 cycles in BYTE1.
  - Required: out_data held at 8'hFF during the BYTE0 stall, then 8'h00 held with out_last=1 during the BYTE1 stall.
  - Both readies stay 0 throughout.
  - Exactly two bytes are transferred.
- Input change after accept: req0 sends 16'hCAFE, then req0_data switches to 16'h0000 the next cycle.
  - Required: bytes emitted are FE, CA.
- Reset mid-word: assert rst during BYTE1 of 16'h8001.
  - Required: next cycle out_valid=0, busy=0, out_data=0.
  - A following simultaneous req0/req1 request grants req0 first.
- LOW_FIRST=0: req0 sends 16'h1234.
  - Required: bytes 12 (out_last=0), then 34 (out_last=1).

Source files
------------

// File: rtl/split16_arbiter.sv
// Round-robin share of one 16->8 splitter between two requesters; each
// accepted word is replayed onto the 8-bit bus as two bytes.
module split16_arbiter #(
   parameter int LOW_FIRST = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   output logic        req1_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        out_src,
   input  logic        out_ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, BYTE0, BYTE1} state_t;

   state_t      state, state_nxt;
   logic [15:0] word_reg;
   logic        src_reg;
   logic        last_grant;
   logic        grant;
   logic        accept;
   logic [7:0]  first_byte, second_byte;

   // Contention goes to whoever did not win last; a lone requester always wins.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant;
      else if (req1_valid)          grant = 1'b1;
   end

   assign accept     = (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid &&  grant;

   assign first_byte  = (LOW_FIRST != 0) ? word_reg[7:0]  : word_reg[15:8];
   assign second_byte = (LOW_FIRST != 0) ? word_reg[15:8] : word_reg[7:0];

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      out_src   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = BYTE0;
         end
         BYTE0: begin
            out_valid = 1'b1;
            out_data  = first_byte;
            out_src   = src_reg;
            busy      = 1'b1;
            if (out_ready) state_nxt = BYTE1;
         end
         BYTE1: begin
            out_valid = 1'b1;
            out_data  = second_byte;
            out_last  = 1'b1;
            out_src   = src_reg;
            busy      = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // last_grant resets to 1 so requester 0 takes the first contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         word_reg   <= 16'h0000;
         src_reg    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (accept) begin
            word_reg   <= grant ? req1_data : req0_data;
            src_reg    <= grant;
            last_grant <= grant;
         end
      end
   end

endmodule

// File: tb/tb_split16_arbiter.sv
// Directed bench for split16_arbiter: one LOW_FIRST=1 instance, one LOW_FIRST=0.
module tb_split16_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, out_ready;
   logic [15:0] req0_data, req1_data;
   logic        req0_ready, req1_ready, out_valid, out_last, out_src, busy;
   logic [7:0]  out_data;

   logic        b_req0_valid, b_req1_valid, b_out_ready;
   logic [15:0] b_req0_data, b_req1_data;
   logic        b_req0_ready, b_req1_ready, b_out_valid, b_out_last, b_out_src, b_busy;
   logic [7:0]  b_out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   split16_arbiter #(.LOW_FIRST(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_src(out_src), .out_ready(out_ready), .busy(busy)
   );

   split16_arbiter #(.LOW_FIRST(0)) dut_hi (
      .clk(clk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
      .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
      .out_src(b_out_src), .out_ready(b_out_ready), .busy(b_busy)
   );

   // Advance one cycle and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if ({out_last, out_src} !== 2'b00) begin errors++; $display("FAIL reset_last_src got %b exp 00", {out_last, out_src}); end
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_data = 16'hA55A; out_ready = 1'b1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      checks++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'h5A, 1'b0, 1'b0})
         begin errors++; $display("FAIL single_byte0 got v%b d%h l%b s%b exp v1 d5a l0 s0", out_valid, out_data, out_last, out_src); end
      tick();
      checks++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'hA5, 1'b1, 1'b0})
         begin errors++; $display("FAIL single_byte1 got v%b d%h l%b s%b exp v1 da5 l1 s0", out_valid, out_data, out_last, out_src); end
      tick();
      checks++; if ({busy, out_valid} !== 2'b00) begin errors++; $display("FAIL single_idle got busy%b v%b exp 0 0", busy, out_valid); end
   endtask

   task automatic test_contention();
      logic [7:0] exp_lo [2];
      logic [7:0] exp_hi [2];
      exp_lo[0] = 8'h34; exp_hi[0] = 8'h12;
      exp_lo[1] = 8'hEF; exp_hi[1] = 8'hBE;
      do_reset();
      req0_valid = 1'b1; req0_data = 16'h1234;
      req1_valid = 1'b1; req1_data = 16'hBEEF;
      out_ready  = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
            begin errors++; $display("FAIL contention_grant%0d got %b", k, {req0_ready, req1_ready}); end
         tick();
         checks++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, exp_lo[k%2], 1'b0, 1'(k%2)})
            begin errors++; $display("FAIL contention_b0_%0d got v%b d%h l%b s%b exp d%h s%0d", k, out_valid, out_data, out_last, out_src, exp_lo[k%2], k%2); end
         tick();
         checks++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, exp_hi[k%2], 1'b1, 1'(k%2)})
            begin errors++; $display("FAIL contention_b1_%0d got v%b d%h l%b s%b exp d%h s%0d", k, out_valid, out_data, out_last, out_src, exp_hi[k%2], k%2); end
         checks++; if ({req0_ready, req1_ready} !== 2'b00)
            begin errors++; $display("FAIL contention_noaccept_byte1_%0d got %b exp 00", k, {req0_ready, req1_ready}); end
         tick();
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL contention_idle%0d got busy %b exp 0", k, busy); end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int xfers = 0;
      req1_valid = 1'b1; req1_data = 16'h00FF; out_ready = 1'b0;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_ready got %b exp 01", {req0_ready, req1_ready}); end
      tick();
      req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 16'h5555;
      #1;
      for (int c = 0; c < 4; c++) begin
         checks++; if ({out_valid, out_data, out_last, req0_ready, req1_ready} !== {1'b1, 8'hFF, 1'b0, 2'b00})
            begin errors++; $display("FAIL bp_stall0_%0d got v%b d%h l%b r%b%b exp v1 dff l0 r00", c, out_valid, out_data, out_last, req0_ready, req1_ready); end
         if (out_valid && out_ready) xfers++;
         tick();
      end
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) xfers++;
      tick();
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 2; c++) begin
         checks++; if ({out_valid, out_data, out_last, req0_ready, req1_ready} !== {1'b1, 8'h00, 1'b1, 2'b00})
            begin errors++; $display("FAIL bp_stall1_%0d got v%b d%h l%b r%b%b exp v1 d00 l1 r00", c, out_valid, out_data, out_last, req0_ready, req1_ready); end
         if (out_valid && out_ready) xfers++;
         tick();
      end
      out_ready = 1'b1; req0_valid = 1'b0;
      #1;
      if (out_valid && out_ready) xfers++;
      tick();
      if (out_valid && out_ready) xfers++;
      tick();
      if (out_valid && out_ready) xfers++;
      checks++; if (xfers !== 2) begin errors++; $display("FAIL bp_xfers got %0d exp 2", xfers); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy %b exp 0", busy); end
   endtask

   task automatic test_input_change();
      req0_valid = 1'b1; req0_data = 16'hCAFE; out_ready = 1'b1;
      tick();
      req0_valid = 1'b0; req0_data = 16'h0000;
      #1;
      checks++; if ({out_valid, out_data} !== {1'b1, 8'hFE}) begin errors++; $display("FAIL hold_b0 got v%b d%h exp v1 dfe", out_valid, out_data); end
      tick();
      checks++; if ({out_valid, out_data} !== {1'b1, 8'hCA}) begin errors++; $display("FAIL hold_b1 got v%b d%h exp v1 dca", out_valid, out_data); end
      tick();
   endtask

   task automatic test_reset_midword();
      req0_valid = 1'b1; req0_data = 16'h8001; out_ready = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      checks++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h80, 1'b1}) begin errors++; $display("FAIL rstmid_b1 got v%b d%h l%b exp v1 d80 l1", out_valid, out_data, out_last); end
      out_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({out_valid, busy, out_data} !== {1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL rstmid_after got v%b busy%b d%h exp v0 busy0 d00", out_valid, busy, out_data); end
      req0_valid = 1'b1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_data = 16'h2222;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_grant got %b exp 10", {req0_ready, req1_ready}); end
      out_ready = 1'b1;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++; if ({out_data, out_src} !== {8'h11, 1'b0}) begin errors++; $display("FAIL rstmid_word got d%h s%b exp d11 s0", out_data, out_src); end
      tick();
      tick();
   endtask

   task automatic test_high_first();
      b_req0_valid = 1'b1; b_req0_data = 16'h1234; b_out_ready = 1'b1;
      tick();
      b_req0_valid = 1'b0;
      checks++; if ({b_out_valid, b_out_data, b_out_last} !== {1'b1, 8'h12, 1'b0}) begin errors++; $display("FAIL hifirst_b0 got v%b d%h l%b exp v1 d12 l0", b_out_valid, b_out_data, b_out_last); end
      tick();
      checks++; if ({b_out_valid, b_out_data, b_out_last} !== {1'b1, 8'h34, 1'b1}) begin errors++; $display("FAIL hifirst_b1 got v%b d%h l%b exp v1 d34 l1", b_out_valid, b_out_data, b_out_last); end
      tick();
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL hifirst_idle got busy %b exp 0", b_busy); end
   endtask

   initial begin
      rst = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
      req0_data = 16'h0; req1_data = 16'h0;
      b_req0_valid = 1'b0; b_req1_valid = 1'b0; b_out_ready = 1'b0;
      b_req0_data = 16'h0; b_req1_data = 16'h0;
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_input_change();
      test_reset_midword();
      test_high_first();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
